// File: rtl/digit_safe_pkg.sv
// Shared constants for the digit-safe front end: button channel indices,
// clock rate and the debounce / auto-repeat timing derived from it.
package digit_safe_pkg;

    // Channel bit positions on the raw button bus
    localparam int BTN_PW_SET    = 0;
    localparam int BTN_UP        = 1;
    localparam int BTN_DOWN      = 2;
    localparam int BTN_SLIDE     = 3;
    localparam int BTN_PLACE     = 4;
    localparam int BTN_OK        = 5;
    localparam int BTN_PW_ENDSET = 6;
    localparam int N_BTN         = 7;

    localparam int CLK_HZ = 25_200_000;

    // 10 ms of stable input before a level change is accepted
    localparam int DEBOUNCE_MS     = 10;
    localparam int DEBOUNCE_CYCLES = (CLK_HZ / 1000) * DEBOUNCE_MS;
    localparam int CNT_W           = 18;

    // Auto-repeat: first repeat after 500 ms of hold, then every 100 ms
    localparam int REPEAT_DELAY_CYCLES  = CLK_HZ / 2;
    localparam int REPEAT_PERIOD_CYCLES = CLK_HZ / 10;
    localparam int REPEAT_CNT_W         = 24;

    // Only up and down repeat while held
    localparam logic [N_BTN-1:0] REPEAT_MASK = 7'b0000110;

    typedef logic [N_BTN-1:0] btn_vec_t;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: two-flop synchroniser, glitch-rejecting debounce
// counter, accepted level and registered press/release pulses.
// Optional auto-repeat on held presses when BTN_AUTOREPEAT_EN is defined.
module btn_debounce_ch #(
    parameter int DEBOUNCE_CYCLES = digit_safe_pkg::DEBOUNCE_CYCLES,
`ifdef BTN_AUTOREPEAT_EN
    parameter bit REPEAT_EN     = 1'b0,
    parameter int REPEAT_DELAY  = digit_safe_pkg::REPEAT_DELAY_CYCLES,
    parameter int REPEAT_PERIOD = digit_safe_pkg::REPEAT_PERIOD_CYCLES,
`endif
    parameter int CNT_W = digit_safe_pkg::CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic pulse,
    output logic release_pulse
);
    import digit_safe_pkg::*;

    // Last count value of a pending change; the change is taken on the next edge
    localparam logic [CNT_W-1:0] ACCEPT_AT = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_p0;
    logic             sync_p1;
    logic [CNT_W-1:0] cnt;
    logic             level_d;
    logic             repeat_fire;

    // Bring the asynchronous pin into the clk domain
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
        end
    end

    // Count consecutive cycles the synchronised input disagrees with the level;
    // any agreement restarts the count, so a bounce earns no partial credit
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (sync_p1 == level) begin
            cnt <= '0;
        end else if (cnt == ACCEPT_AT) begin
            level <= ~level;
            cnt   <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Registered one-cycle pulses on accepted rising and falling edges
    always_ff @(posedge clk) begin
        if (rst) begin
            level_d       <= 1'b0;
            pulse         <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            level_d       <= level;
            pulse         <= (level & ~level_d) | repeat_fire;
            release_pulse <= ~level & level_d;
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    generate
        if (REPEAT_EN) begin : g_repeat
            localparam logic [REPEAT_CNT_W-1:0] FIRE_AT = REPEAT_CNT_W'(REPEAT_DELAY);
            // After a repeat, restart so the next one lands one period later
            localparam logic [REPEAT_CNT_W-1:0] RELOAD  =
                REPEAT_CNT_W'(REPEAT_DELAY - REPEAT_PERIOD + 1);

            logic [REPEAT_CNT_W-1:0] rep_cnt;

            // Hold timer: runs while the level is high, cleared on release
            always_ff @(posedge clk) begin
                if (rst || !level) begin
                    rep_cnt <= '0;
                end else if (rep_cnt == FIRE_AT) begin
                    rep_cnt <= RELOAD;
                end else begin
                    rep_cnt <= rep_cnt + REPEAT_CNT_W'(1);
                end
            end

            assign repeat_fire = level && (rep_cnt == FIRE_AT);
        end else begin : g_no_repeat
            assign repeat_fire = 1'b0;
        end
    endgenerate
`else
    assign repeat_fire = 1'b0;
`endif

endmodule

// File: rtl/btn_conditioner.sv
// Button/switch conditioning ahead of password_manager: every channel is
// synchronised and debounced independently, producing a clean level plus
// press and release pulses; any_press flags a press on any channel.
// Build option: define BTN_AUTOREPEAT_EN to add auto-repeat on REPEAT_MASK
// channels (default build has no repeat logic).
module btn_conditioner #(
    parameter int N_BTN           = digit_safe_pkg::N_BTN,
    parameter int DEBOUNCE_CYCLES = digit_safe_pkg::DEBOUNCE_CYCLES,
`ifdef BTN_AUTOREPEAT_EN
    parameter logic [N_BTN-1:0] REPEAT_MASK = digit_safe_pkg::REPEAT_MASK,
    parameter int REPEAT_DELAY  = digit_safe_pkg::REPEAT_DELAY_CYCLES,
    parameter int REPEAT_PERIOD = digit_safe_pkg::REPEAT_PERIOD_CYCLES,
`endif
    parameter int CNT_W = digit_safe_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_pulse,
    output logic [N_BTN-1:0] btn_release,
    output logic             any_press
);
    import digit_safe_pkg::*;

    generate
        for (genvar i = 0; i < N_BTN; i++) begin : g_ch
            btn_debounce_ch #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
`ifdef BTN_AUTOREPEAT_EN
                .REPEAT_EN      (REPEAT_MASK[i]),
                .REPEAT_DELAY   (REPEAT_DELAY),
                .REPEAT_PERIOD  (REPEAT_PERIOD),
`endif
                .CNT_W          (CNT_W)
            ) u_ch (
                .clk          (clk),
                .rst          (rst),
                .raw          (btn_raw[i]),
                .level        (btn_level[i]),
                .pulse        (btn_pulse[i]),
                .release_pulse(btn_release[i])
            );
        end
    endgenerate

    // Pulses are already registered, so this OR lines up with them
    assign any_press = |btn_pulse;

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner with a short debounce window (4 cycles) and,
// when BTN_AUTOREPEAT_EN is defined, a 20-cycle repeat delay / 5-cycle period.
module tb_btn_conditioner;
    localparam int NB = 7;
    localparam int D  = 4;
`ifdef BTN_AUTOREPEAT_EN
    localparam int RD = 20;
    localparam int RP = 5;
    localparam logic [NB-1:0] RMASK = 7'b0000110;
`endif

    logic          clk     = 1'b0;
    logic          rst     = 1'b1;
    logic [NB-1:0] btn_raw = '0;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_pulse;
    logic [NB-1:0] btn_release;
    logic          any_press;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    btn_conditioner #(
        .N_BTN          (NB),
        .DEBOUNCE_CYCLES(D),
`ifdef BTN_AUTOREPEAT_EN
        .REPEAT_MASK    (RMASK),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP),
`endif
        .CNT_W          (18)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_pulse  (btn_pulse),
        .btn_release(btn_release),
        .any_press  (any_press)
    );

    // Reference model: level changes once the synchronised input has
    // disagreed with it for D consecutive cycles.
    logic [NB-1:0] m_p0    = '0;
    logic [NB-1:0] m_level = '0;
    logic [NB-1:0] m_l1    = '0;
    logic [NB-1:0] m_pulse = '0;
    logic [NB-1:0] m_rel   = '0;
    logic [NB-1:0] s_h[$];
    int            rise_at[NB];
    int            ecnt = 0;

    logic [3*NB:0] dut_vec;
    logic [3*NB:0] mod_vec;
    assign dut_vec = {btn_level, btn_pulse, btn_release, any_press};
    assign mod_vec = {m_level, m_pulse, m_rel, |m_pulse};

    initial begin
        for (int i = 0; i < D; i++) s_h.push_back('0);
        for (int i = 0; i < NB; i++) rise_at[i] = -1;
    end

    always @(posedge clk) begin : model
        logic [NB-1:0] lb;
        logic [NB-1:0] l1b;
        logic [NB-1:0] s_now;
        logic [NB-1:0] past;
        bit            diff;
        lb   = m_level;
        l1b  = m_l1;
        ecnt = ecnt + 1;
        if (rst) begin
            m_p0    = '0;
            s_now   = '0;
            m_level = '0;
            m_l1    = '0;
            m_pulse = '0;
            m_rel   = '0;
            for (int ch = 0; ch < NB; ch++) rise_at[ch] = -1;
        end else begin
            s_now   = m_p0;
            m_p0    = btn_raw;
            m_level = lb;
            for (int ch = 0; ch < NB; ch++) begin
                diff = 1'b1;
                for (int j = 1; j <= D; j++) begin
                    past = s_h[s_h.size() - j];
                    if (past[ch] == lb[ch]) diff = 1'b0;
                end
                if (diff) m_level[ch] = ~lb[ch];
            end
            m_pulse = lb & ~l1b;
            m_rel   = ~lb & l1b;
            m_l1    = lb;
`ifdef BTN_AUTOREPEAT_EN
            for (int ch = 0; ch < NB; ch++) begin
                if (!lb[ch]) rise_at[ch] = -1;
                if (m_pulse[ch]) rise_at[ch] = ecnt;
                else if (RMASK[ch] && lb[ch] && rise_at[ch] >= 0 &&
                         (ecnt - rise_at[ch]) >= RD &&
                         ((ecnt - rise_at[ch] - RD) % RP) == 0)
                    m_pulse[ch] = 1'b1;
            end
`endif
        end
        s_h.push_back(s_now);
        if (s_h.size() > 2 * D) void'(s_h.pop_front());
    end

    task automatic test_reset();
        rst     = 1'b1;
        btn_raw = NB'($urandom);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #2;
            checks++;
            if (dut_vec !== '0) begin
                failures++;
                $display("FAIL reset_state: got %h, expected 0", dut_vec);
            end
            btn_raw = NB'($urandom);
        end
        rst     = 1'b0;
        btn_raw = '0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #2;
            checks++;
            if (dut_vec !== mod_vec) begin
                failures++;
                $display("FAIL reset_idle edge %0d: got %h, expected %h", ecnt, dut_vec, mod_vec);
            end
        end
    endtask

    task automatic test_clean_press();
        int start_e, lvl_e, pls_e, npulse, rel_e, nrel;
        btn_raw[5] = 1'b1;
        start_e = ecnt; lvl_e = -1; pls_e = -1; npulse = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #2;
            checks++;
            if (dut_vec !== mod_vec) begin
                failures++;
                $display("FAIL clean_press edge %0d: got %h, expected %h", ecnt, dut_vec, mod_vec);
            end
            if (btn_level[5] === 1'b1 && lvl_e < 0) lvl_e = ecnt;
            if (btn_pulse[5] === 1'b1 && any_press === 1'b1) begin
                npulse++;
                pls_e = ecnt;
            end
        end
        checks++;
        if (lvl_e !== start_e + 6) begin
            failures++;
            $display("FAIL clean_press_level_time: got +%0d, expected +6", lvl_e - start_e);
        end
        checks++;
        if (pls_e !== start_e + 7 || npulse !== 1) begin
            failures++;
            $display("FAIL clean_press_pulse: got +%0d count %0d, expected +7 count 1", pls_e - start_e, npulse);
        end
        btn_raw[5] = 1'b0;
        start_e = ecnt; rel_e = -1; nrel = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #2;
            checks++;
            if (dut_vec !== mod_vec) begin
                failures++;
                $display("FAIL clean_release edge %0d: got %h, expected %h", ecnt, dut_vec, mod_vec);
            end
            if (btn_release[5] === 1'b1) begin
                nrel++;
                rel_e = ecnt;
            end
        end
        checks++;
        if (rel_e !== start_e + 7 || nrel !== 1) begin
            failures++;
            $display("FAIL clean_release_pulse: got +%0d count %0d, expected +7 count 1", rel_e - start_e, nrel);
        end
    endtask

    task automatic test_glitch();
        logic seen;
        seen = 1'b0;
        btn_raw[1] = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #2;
            checks++;
            if (dut_vec !== mod_vec) begin
                failures++;
                $display("FAIL glitch edge %0d: got %h, expected %h", ecnt, dut_vec, mod_vec);
            end
            if (btn_level[1] !== 1'b0 || btn_pulse[1] !== 1'b0) seen = 1'b1;
            if (c == 2) btn_raw[1] = 1'b0;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL glitch_rejected: got activity=%b, expected 0", seen);
        end
    endtask

    task automatic test_bounce();
        logic [8:0] pat;
        int rise_e, pls_e, npulse;
        pat = 9'b111101101;
        btn_raw[2] = pat[0];
        rise_e = ecnt; pls_e = -1; npulse = 0;
        for (int c = 0; c < 21; c++) begin
            @(posedge clk); #2;
            checks++;
            if (dut_vec !== mod_vec) begin
                failures++;
                $display("FAIL bounce edge %0d: got %h, expected %h", ecnt, dut_vec, mod_vec);
            end
            if (btn_pulse[2] === 1'b1) begin
                npulse++;
                pls_e = ecnt;
            end
            if (c + 1 < 9) begin
                btn_raw[2] = pat[c + 1];
                if (pat[c + 1] && !pat[c]) rise_e = ecnt;
            end
        end
        checks++;
        if (npulse !== 1 || pls_e !== rise_e + 7) begin
            failures++;
            $display("FAIL bounce_pulse: got count %0d at +%0d, expected count 1 at +7", npulse, pls_e - rise_e);
        end
        btn_raw[2] = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #2;
            checks++;
            if (dut_vec !== mod_vec) begin
                failures++;
                $display("FAIL bounce_release edge %0d: got %h, expected %h", ecnt, dut_vec, mod_vec);
            end
        end
    endtask

    task automatic test_simultaneous();
        int start_e, e0, e6, n0, n6;
        btn_raw[0] = 1'b1;
        btn_raw[6] = 1'b1;
        start_e = ecnt; e0 = -1; e6 = -1; n0 = 0; n6 = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #2;
            checks++;
            if (dut_vec !== mod_vec) begin
                failures++;
                $display("FAIL simul_press edge %0d: got %h, expected %h", ecnt, dut_vec, mod_vec);
            end
            if (btn_pulse[0] === 1'b1) begin n0++; e0 = ecnt; end
            if (btn_pulse[6] === 1'b1) begin n6++; e6 = ecnt; end
        end
        checks++;
        if (n0 !== 1 || n6 !== 1 || e0 !== start_e + 7 || e6 !== start_e + 7) begin
            failures++;
            $display("FAIL simul_pulses: got ch0 %0d@+%0d ch6 %0d@+%0d, expected 1@+7 each", n0, e0 - start_e, n6, e6 - start_e);
        end
        btn_raw[0] = 1'b0;
        btn_raw[6] = 1'b0;
        start_e = ecnt; e0 = -1; e6 = -1; n0 = 0; n6 = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #2;
            checks++;
            if (dut_vec !== mod_vec) begin
                failures++;
                $display("FAIL simul_release edge %0d: got %h, expected %h", ecnt, dut_vec, mod_vec);
            end
            if (btn_release[0] === 1'b1) begin n0++; e0 = ecnt; end
            if (btn_release[6] === 1'b1) begin n6++; e6 = ecnt; end
        end
        checks++;
        if (n0 !== 1 || n6 !== 1 || e0 !== start_e + 7 || e6 !== start_e + 7) begin
            failures++;
            $display("FAIL simul_releases: got ch0 %0d@+%0d ch6 %0d@+%0d, expected 1@+7 each", n0, e0 - start_e, n6, e6 - start_e);
        end
    endtask

    task automatic test_reset_mid();
        int start_e, pls_e, npulse;
        btn_raw[4] = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #2;
            checks++;
            if (dut_vec !== mod_vec) begin
                failures++;
                $display("FAIL reset_mid_pre edge %0d: got %h, expected %h", ecnt, dut_vec, mod_vec);
            end
        end
        rst = 1'b1;
        @(posedge clk); #2;
        checks++;
        if (dut_vec !== '0) begin
            failures++;
            $display("FAIL reset_mid_clear: got %h, expected 0", dut_vec);
        end
        rst = 1'b0;
        start_e = ecnt; pls_e = -1; npulse = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #2;
            checks++;
            if (dut_vec !== mod_vec) begin
                failures++;
                $display("FAIL reset_mid edge %0d: got %h, expected %h", ecnt, dut_vec, mod_vec);
            end
            if (btn_pulse[4] === 1'b1) begin
                npulse++;
                pls_e = ecnt;
            end
        end
        checks++;
        if (npulse !== 1 || pls_e !== start_e + 7) begin
            failures++;
            $display("FAIL reset_mid_pulse: got count %0d at +%0d, expected count 1 at +7", npulse, pls_e - start_e);
        end
        btn_raw[4] = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #2;
            checks++;
            if (dut_vec !== mod_vec) begin
                failures++;
                $display("FAIL reset_mid_release edge %0d: got %h, expected %h", ecnt, dut_vec, mod_vec);
            end
        end
    endtask

`ifdef BTN_AUTOREPEAT_EN
    task automatic test_autorepeat();
        int p_e, n3, k;
        int offs[$];
        int want[5];
        want = '{20, 25, 30, 35, 40};
        btn_raw[1] = 1'b1;
        btn_raw[3] = 1'b1;
        p_e = -1;
        for (int c = 0; c < 15 && p_e < 0; c++) begin
            @(posedge clk); #2;
            checks++;
            if (dut_vec !== mod_vec) begin
                failures++;
                $display("FAIL repeat_first edge %0d: got %h, expected %h", ecnt, dut_vec, mod_vec);
            end
            if (btn_pulse[1] === 1'b1) p_e = ecnt;
        end
        checks++;
        if (p_e < 0 || btn_pulse[3] !== 1'b1) begin
            failures++;
            $display("FAIL repeat_first_pulse: got up=%0d slide=%b, expected both pulsing", p_e, btn_pulse[3]);
        end
        n3 = 0;
        for (int c = 0; c < 42; c++) begin
            @(posedge clk); #2;
            checks++;
            if (dut_vec !== mod_vec) begin
                failures++;
                $display("FAIL repeat_hold edge %0d: got %h, expected %h", ecnt, dut_vec, mod_vec);
            end
            if (btn_pulse[1] === 1'b1) offs.push_back(ecnt - p_e);
            if (btn_pulse[3] === 1'b1) n3++;
        end
        checks++;
        if (offs.size() !== 5) begin
            failures++;
            $display("FAIL repeat_count: got %0d repeats, expected 5", offs.size());
        end
        k = (offs.size() < 5) ? offs.size() : 5;
        for (int i = 0; i < k; i++) begin
            checks++;
            if (offs[i] !== want[i]) begin
                failures++;
                $display("FAIL repeat_offset %0d: got +%0d, expected +%0d", i, offs[i], want[i]);
            end
        end
        checks++;
        if (n3 !== 0) begin
            failures++;
            $display("FAIL slide_no_repeat: got %0d extra pulses, expected 0", n3);
        end
        btn_raw = '0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #2;
            checks++;
            if (dut_vec !== mod_vec) begin
                failures++;
                $display("FAIL repeat_release edge %0d: got %h, expected %h", ecnt, dut_vec, mod_vec);
            end
        end
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk); #2;
            checks++;
            if (dut_vec !== mod_vec) begin
                failures++;
                $display("FAIL random edge %0d: got %h, expected %h", ecnt, dut_vec, mod_vec);
            end
            if ($urandom_range(0, 3) == 0) btn_raw = btn_raw ^ NB'(1 << $urandom_range(0, NB - 1));
            rst = ($urandom_range(0, 299) == 0);
        end
        rst     = 1'b0;
        btn_raw = '0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #2;
            checks++;
            if (dut_vec !== mod_vec) begin
                failures++;
                $display("FAIL random_settle edge %0d: got %h, expected %h", ecnt, dut_vec, mod_vec);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_glitch();
        test_bounce();
        test_simultaneous();
        test_reset_mid();
`ifdef BTN_AUTOREPEAT_EN
        test_autorepeat();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
